// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the datapath and the loader port.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise the datapath has fixed priority.
module dmem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [31:0]       ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_done,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            state;
  logic [3:0]        cnt;
  logic              owner;
  logic              last;
  logic              win_ld;
  logic              g_we;
  logic [31:0]       g_addr;
  logic [DATA_W-1:0] g_wdata;
`ifdef DMEM_ARB_RR_EN
  assign win_ld = ld_req & (~cpu_req | ~last);
`else
  assign win_ld = ld_req & ~cpu_req;
`endif
  always_comb begin
    g_we    = win_ld ? ld_we : cpu_we;
    g_addr  = win_ld ? ld_addr : cpu_addr;
    g_wdata = win_ld ? ld_wdata : cpu_wdata;
  end
  // cpu_done is high exactly while a datapath access sits in DONE
  assign cpu_stall = cpu_req & ~cpu_done;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      owner     <= 1'b0;
      last      <= 1'b1;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      ld_rdata  <= '0;
      cpu_done  <= 1'b0;
      ld_done   <= 1'b0;
      err       <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      ld_done  <= 1'b0;
      err      <= 1'b0;
      last     <= (state == BUSY && cnt == 4'd0) ? owner : last;
      case (state)
        IDLE: if (cpu_req | ld_req) begin
          owner     <= win_ld;
          mem_addr  <= g_addr;
          mem_wdata <= g_wdata;
          if (|g_addr[1:0]) begin
            state    <= DONE;
            mem_we   <= 1'b0;
            cpu_done <= ~win_ld;
            ld_done  <= win_ld;
            err      <= 1'b1;
            if (win_ld) ld_rdata <= '0;
            else cpu_rdata <= '0;
          end else begin
            state  <= BUSY;
            mem_en <= 1'b1;
            mem_we <= g_we;
            cnt    <= 4'(MEM_LAT - 1);
          end
        end
        BUSY: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else begin
          state    <= DONE;
          mem_en   <= 1'b0;
          mem_we   <= 1'b0;
          cpu_done <= ~owner;
          ld_done  <= owner;
          if (owner) ld_rdata <= mem_we ? '0 : mem_rdata;
          else cpu_rdata <= mem_we ? '0 : mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a transaction-level model checked every cycle.
module tb_dmem_arbiter;
  localparam int L = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic cpu_req = 1'b0, cpu_we = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, ld_addr = '0, ld_wdata = '0;
  logic [31:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_done, cpu_stall, ld_done, err, mem_en, mem_we;
  logic c1_req = 1'b0, c1_we = 1'b0;
  logic [31:0] c1_addr = '0, c1_wdata = '0;
  logic [31:0] c1_rdata, l1_rdata, m1_addr, m1_wdata, m1_rdata;
  logic c1_done, c1_stall, l1_done, e1, m1_en, m1_we;
  logic [31:0] ram [64];
  logic [31:0] ram1 [64];
  logic [31:0] mmem [64];
  int n_chk = 0, n_err = 0, ld_cnt = 0;

  dmem_arbiter #(.DATA_W(32), .MEM_LAT(L)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_done(ld_done), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  dmem_arbiter #(.DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
    .cpu_rdata(c1_rdata), .cpu_done(c1_done), .cpu_stall(c1_stall),
    .ld_req(1'b0), .ld_we(1'b0), .ld_addr(32'h0), .ld_wdata(32'h0),
    .ld_rdata(l1_rdata), .ld_done(l1_done), .err(e1),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'h37 : 32'(32'h1000 + i);
  endfunction

  assign mem_rdata = ram[mem_addr[7:2]];
  assign m1_rdata  = ram1[m1_addr[7:2]];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) begin
        ram[i]  <= init_word(i);
        ram1[i] <= init_word(i);
      end
    end else begin
      if (mem_en && mem_we) ram[mem_addr[7:2]] <= mem_wdata;
      if (m1_en && m1_we) ram1[m1_addr[7:2]] <= m1_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction model: edge index of each grant fixes the BUSY window and the done cycle.
  int cyc, free_at, t0;
  bit m_act, m_own, m_we, m_mis, m_last;
  logic [31:0] m_addr, m_wd, m_rd;
  always @(posedge clk) begin
    if (!reset) begin
      cyc = 0; free_at = 0; m_act = 0; m_last = 1;
      for (int i = 0; i < 64; i++) mmem[i] = init_word(i);
    end else begin
      cyc++;
      if (cyc >= free_at && (cpu_req || ld_req)) begin
`ifdef DMEM_ARB_RR_EN
        m_own = ld_req && (!cpu_req || !m_last);
`else
        m_own = ld_req && !cpu_req;
`endif
        m_we   = m_own ? ld_we : cpu_we;
        m_addr = m_own ? ld_addr : cpu_addr;
        m_wd   = m_own ? ld_wdata : cpu_wdata;
        m_mis  = m_addr[1:0] != 2'b00;
        t0 = cyc; m_act = 1;
        free_at = cyc + (m_mis ? 2 : L + 2);
        m_rd = (m_we || m_mis) ? 32'h0 : mmem[m_addr[7:2]];
        if (!m_mis) begin
          m_last = m_own;
          if (m_we) mmem[m_addr[7:2]] = m_wd;
        end
      end
    end
  end

  bit en_x, dn, cd_x, ld_x;
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_dones", {cpu_done, ld_done, err}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_ld_rdata", ld_rdata, 0);
      chk("rst_stall", cpu_stall, cpu_req);
    end else begin
      en_x = m_act && !m_mis && cyc >= t0 && cyc < t0 + L;
      dn   = m_act && cyc == t0 + (m_mis ? 0 : L);
      cd_x = dn && !m_own;
      ld_x = dn && m_own;
      chk("mem_en", mem_en, en_x);
      chk("cpu_done", cpu_done, cd_x);
      chk("ld_done", ld_done, ld_x);
      chk("err", err, dn && m_mis);
      chk("cpu_stall", cpu_stall, cpu_req && !cd_x);
      if (en_x) begin
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        if (m_we) chk("mem_wdata", mem_wdata, m_wd);
      end
      if (cd_x) chk("cpu_rdata", cpu_rdata, m_rd);
      if (ld_x) chk("ld_rdata", ld_rdata, m_rd);
      if (ld_done) ld_cnt++;
    end
  end

  task automatic run(input bit who, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output int lat, output int ens, output int stalls,
                     output bit e);
    bit found = 0;
    @(negedge clk); #1;
    if (who) begin ld_req = 1; ld_we = we; ld_addr = a; ld_wdata = wd; end
    else begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    #1 stalls = int'(cpu_stall);
    lat = 0; ens = 0; rd = '0; e = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      lat++;
      ens += int'(mem_en);
      stalls += int'(cpu_stall);
      if (who ? ld_done : cpu_done) begin
        found = 1; rd = who ? ld_rdata : cpu_rdata; e = err;
      end
    end
    chk("done_seen", found, 1);
    #1 cpu_req = 0; ld_req = 0;
  endtask

  logic [31:0] rd;
  int lat, ens, stalls, ld0, n;
  bit e;
  bit seq [4];
  initial begin
    repeat (2) @(negedge clk);
    #1 reset = 1;
    run(0, 0, 32'h8, 32'h0, rd, lat, ens, stalls, e);
    chk("load_rdata", rd, 32'h37);
    chk("load_lat", lat, 3);
    chk("load_en_cycles", ens, 2);
    chk("load_stall_cycles", stalls, 3);
    chk("load_err", e, 0);
    ld0 = ld_cnt;
    run(1, 1, 32'h8, 32'h8, rd, lat, ens, stalls, e);
    chk("ldst_en_cycles", ens, 2);
    chk("ldst_stall_cycles", stalls, 0);
    run(0, 0, 32'h8, 32'h0, rd, lat, ens, stalls, e);
    chk("ld_then_cpu_rdata", rd, 32'h8);
    #1 chk("ld_done_once", ld_cnt - ld0, 1);
    run(0, 0, 32'h6, 32'h0, rd, lat, ens, stalls, e);
    chk("mis_lat", lat, 1);
    chk("mis_en_cycles", ens, 0);
    chk("mis_err", e, 1);
    chk("mis_rdata", rd, 0);
    @(negedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8;
    @(posedge clk); #2;
    chk("pre_rst_busy", mem_en, 1);
    reset = 0;
    #1;
    chk("rstmid_en", mem_en, 0);
    chk("rstmid_dones", {cpu_done, ld_done, err}, 0);
    chk("rstmid_stall_hi", cpu_stall, 1);
    cpu_req = 0;
    #1 chk("rstmid_stall_lo", cpu_stall, 0);
    @(posedge clk); @(negedge clk); #1 reset = 1;
    ld0 = ld_cnt;
    @(negedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'hC;
    ld_req = 1; ld_we = 0; ld_addr = 32'h10;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (cpu_done) begin seq[n] = 0; n++; end
      else if (ld_done) begin seq[n] = 1; n++; end
    end
    #1 cpu_req = 0; ld_req = 0;
    chk("cont_grants", n, 4);
`ifdef DMEM_ARB_RR_EN
    for (int i = 0; i < 4; i++) chk("cont_owner", seq[i], i % 2);
    chk("cont_ld_dones", ld_cnt - ld0, 2);
`else
    for (int i = 0; i < 4; i++) chk("cont_owner", seq[i], 0);
    chk("cont_ld_dones", ld_cnt - ld0, 0);
`endif
    @(negedge clk); #1;
    c1_req = 1; c1_we = 1; c1_addr = 32'h10; c1_wdata = 32'hAB;
    @(negedge clk);
    chk("l1_en", m1_en, 1);
    chk("l1_we", m1_we, 1);
    chk("l1_addr", m1_addr, 32'h10);
    chk("l1_early_done", c1_done, 0);
    #1 c1_req = 0;
    @(negedge clk);
    chk("l1_done", c1_done, 1);
    chk("l1_en_off", m1_en, 0);
    chk("l1_err", e1, 0);
    @(negedge clk);
    chk("l1_single_done", c1_done, 0);
    chk("l1_committed", ram1[4], 32'hAB);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-ported data memory between the processor datapath (load/store port) and a program/data loader port. Grants one requester at a time, runs each access for a fixed memory latency and stalls the datapath until its access completes. Sits between the datapath's ALU-result/readData2 outputs and the data memory, and replaces direct memRead/memWrite drive of the memory.

## Interface
- `DATA_W`, 32, data width of read and write data.
- `MEM_LAT`, 2, memory access latency in cycles; legal range is 1..15.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  datapath access request (memRead | memWrite).
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  32  byte address (ALU result).
- `cpu_wdata`  in  DATA_W  store data.
- `cpu_rdata`  out  DATA_W  load data; valid while `cpu_done` is high.
- `cpu_done`  out  1  one-cycle completion pulse for a datapath access.
- `cpu_stall`  out  1  freezes the PC and register write.
- `ld_req`, `ld_we`, `ld_addr[31:0]`, `ld_wdata[DATA_W-1:0]`  in  loader request fields; same meaning as the `cpu_` fields.
- `ld_rdata`  out  DATA_W  loader read data.
- `ld_done`  out  1  loader completion pulse.
- `err`  out  1  pulses together with a done pulse when the completed access was misaligned.
- `mem_en`, `mem_we`  out  1  memory enable and write enable.
- `mem_addr`  out  32  byte address to the memory.
- `mem_wdata`  out  DATA_W  write data to the memory.
- `mem_rdata`  in  DATA_W  memory read data; valid in the last BUSY cycle.

## Operation
- FSM states: IDLE, BUSY, DONE. A 4-bit down-counter `cnt` and an `owner` bit (0 = CPU, 1 = loader) are registered. A `last` bit records the previous grant.
- **IDLE**
  - If no request is present, remain in IDLE.
  - Otherwise pick the winner per Configuration, then latch `owner`, we, addr and wdata.
  - If the latched addr[1:0] is not 0, go to DONE with the error flag set and no memory access.
  - Otherwise go to BUSY with `cnt` = MEM_LAT-1.
- **BUSY**
  - `mem_en` = 1, and `mem_we`/`mem_addr`/`mem_wdata` are driven from the latched values.
  - If `cnt` is not 0, decrement it.
  - If `cnt` is 0, capture `mem_rdata` into the owner's rdata register (cleared to 0 on a write), update `last` = `owner`, and go to DONE.
- **DONE**
  - Assert the owner's done for exactly one cycle, and `err` if flagged.
  - For a misaligned access, rdata is 0. Then go to IDLE.
- `cpu_stall` = `cpu_req` & ~(DONE & owner==CPU). This is combinational from the request and registered state.
- Each requester must hold its request and fields stable until its done pulse. Fields are latched in IDLE, so later changes have no effect.
- A request dropped mid-access does not abort it: the write is still committed and the done pulse is still issued.
- The done pulse goes only to the owner. The other requester sees no response and keeps waiting.

## Timing
- On reset assertion, regardless of state:
  - State is IDLE, `cnt` = 0, `owner` = 0 and `last` = 1 (CPU wins the first tie).
  - The rdata registers are 0.
  - `mem_en`, `mem_we`, `cpu_done`, `ld_done` and `err` are 0. `mem_addr` and `mem_wdata` are 0.
  - `cpu_stall` follows `cpu_req`.
- Reset mid-access abandons the access; a write in progress may or may not have reached memory.
- Aligned access: request sampled at edge k → BUSY for MEM_LAT cycles → done high in the cycle after edge k+MEM_LAT.
  - Occupancy is MEM_LAT+2 cycles including the IDLE sampling cycle.
- Misaligned access: done and `err` are high in the cycle after edge k.
- Back-to-back accesses always have at least one IDLE cycle between them. The maximum rate is one access per MEM_LAT+2 cycles.
- A datapath load or store therefore stalls the core for MEM_LAT+1 cycles when uncontended.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - On simultaneous requests in IDLE, the requester ≠ `last` wins.
  - A single requester always wins.
- `DMEM_ARB_RR_EN` undefined: fixed priority, where CPU always beats loader.
  - `last` is still maintained but unused.
  - The loader can be starved by continuous CPU requests.

## Test plan
- **Reset:** reset low mid-BUSY → state IDLE, `mem_en`=0, all done/`err`=0 within the same cycle; `cpu_stall`=`cpu_req`.
- **Single CPU load** (MEM_LAT=2), memory word at 0x8 = 0x37:
  - Expected: `mem_en` high 2 cycles, `cpu_done` pulse one cycle later with `cpu_rdata`=0x37.
  - Expected: `cpu_stall` high 3 cycles, then low.
- **Loader store then CPU load:** loader stores 0x8 to 0x8, then CPU loads 0x8 → `cpu_rdata`=0x8; `ld_done` pulses exactly once.
- **Contention:** `cpu_req` and `ld_req` are both held high continuously.
  - With `DMEM_ARB_RR_EN`: grants alternate CPU, LD, CPU, LD, with the first grant to CPU.
  - Without it: all grants go to CPU and `ld_done` stays 0.
- **Misaligned:** CPU load at address 0x6 → `mem_en` never high; `cpu_done`=`err`=1 one cycle after sampling, `cpu_rdata`=0.
- **MEM_LAT=1 boundary, request dropped mid-BUSY:**
  - Expected: one BUSY cycle.
  - Expected: the store to 0x10 with data 0xAB is committed and `cpu_done` still pulses.
